// File: rtl/led_pulse_out.sv
// Event-to-LED blinker: one blink per event with a guaranteed on-time and off-gap, plus a saturating event queue.
// Define LED_ACTIVE_LOW_EN to invert ExtLED for common-anode LEDs (lit=0, dark=1).
module led_pulse_out #(
  parameter int unsigned ON_CYCLES  = 7200000,
  parameter int unsigned OFF_CYCLES = 7200000,
  parameter int unsigned PEND_W     = 3
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              IntEVT,
  output logic              ExtLED,
  output logic              Busy,
  output logic [PEND_W-1:0] Pending,
  output logic              Overflow
);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LIT = 1'b0;
`else
  localparam logic LIT = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  localparam logic [25:0]     ON_LAST  = 26'(ON_CYCLES - 1);
  localparam logic [25:0]     OFF_LAST = 26'(OFF_CYCLES - 1);
  localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};
  localparam logic [PEND_W:0] ONE      = {{PEND_W{1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [25:0]       phase, phase_nx;
  logic [PEND_W-1:0] pend_nx;
  logic              ovf_nx, led_nx;
  logic [PEND_W:0]   eff, eff_dec;
  logic              gap_last, start;

  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      state    <= IDLE;
      phase    <= '0;
      Pending  <= '0;
      Overflow <= 1'b0;
      ExtLED   <= ~LIT;
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      Pending  <= pend_nx;
      Overflow <= ovf_nx;
      ExtLED   <= led_nx;
    end
  end

  always_comb begin
    // eff is one bit wider than Pending so a full queue plus a new event is visible
    eff      = {1'b0, Pending} + {{PEND_W{1'b0}}, IntEVT};
    eff_dec  = eff - ONE;
    gap_last = (state == GAP) && (phase == OFF_LAST);
    start    = ((state == IDLE) || gap_last) && (eff != '0);

    state_nx = state;
    phase_nx = phase;
    pend_nx  = Pending;
    ovf_nx   = Overflow;

    if (start) begin
      pend_nx = eff_dec[PEND_W-1:0];
    end else if (eff > PEND_MAX) begin
      pend_nx = PEND_MAX[PEND_W-1:0];
      ovf_nx  = 1'b1;
    end else begin
      pend_nx = eff[PEND_W-1:0];
    end

    case (state)
      IDLE: begin
        phase_nx = '0;
        if (start) state_nx = ON;
      end
      ON: begin
        if (phase == ON_LAST) begin
          state_nx = GAP;
          phase_nx = '0;
        end else begin
          phase_nx = phase + 26'd1;
        end
      end
      GAP: begin
        if (gap_last) begin
          // a queued or same-cycle event chains straight into the next blink
          state_nx = start ? ON : IDLE;
          phase_nx = '0;
        end else begin
          phase_nx = phase + 26'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        phase_nx = '0;
      end
    endcase

    led_nx = (state_nx == ON) ? LIT : ~LIT;
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_led_pulse_out.sv
// Scoreboard bench for led_pulse_out: the driver pushes hand-derived per-edge expectations, a negedge monitor pops and compares.
module tb_led_pulse_out;
  localparam int ON = 3, OFF = 2, PW = 2, NMAX = 40;

  logic          Fg_CLK = 1'b0, RESETn = 1'b0, IntEVT = 1'b0;
  logic          ExtLED, Busy, Overflow;
  logic [PW-1:0] Pending;

  led_pulse_out #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .PEND_W(PW)) dut (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .IntEVT(IntEVT),
    .ExtLED(ExtLED), .Busy(Busy), .Pending(Pending), .Overflow(Overflow)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  typedef struct {
    int            cyc;
    int            edge_n;
    string         nm;
    logic          led, busy, ovf;
    logic [PW-1:0] pend;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, checks = 0, failures = 0;

  always @(posedge Fg_CLK) cyc <= cyc + 1;

  // per-scenario stimulus and expectation tables, indexed by edge number
  logic          s_evt[1:NMAX], s_rst[1:NMAX];
  logic          x_led[1:NMAX], x_busy[1:NMAX], x_ovf[1:NMAX];
  logic [PW-1:0] x_pend[1:NMAX];

  task automatic chk(input string nm, input int e, input string sig, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge %0d %s: got %0h, expected %0h", nm, e, sig, act, exp);
    end
  endtask

  always @(negedge Fg_CLK) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t m;
      m = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s edge %0d missed: monitor cycle %0d, expected %0d", m.nm, m.edge_n, cyc, m.cyc);
    end
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t m;
      m = q.pop_front();
      chk(m.nm, m.edge_n, "ExtLED",   {7'b0, ExtLED},   {7'b0, m.led});
      chk(m.nm, m.edge_n, "Busy",     {7'b0, Busy},     {7'b0, m.busy});
      chk(m.nm, m.edge_n, "Pending",  {6'b0, Pending},  {6'b0, m.pend});
      chk(m.nm, m.edge_n, "Overflow", {7'b0, Overflow}, {7'b0, m.ovf});
    end
  end

  task automatic clr();
    for (int i = 1; i <= NMAX; i++) begin
      s_evt[i] = 1'b0; s_rst[i] = 1'b1;
      x_led[i] = 1'b0; x_busy[i] = 1'b0; x_ovf[i] = 1'b0; x_pend[i] = '0;
    end
  endtask

  task automatic pulse(input int a, input int b);
    for (int i = a; i <= b; i++) s_evt[i] = 1'b1;
  endtask
  task automatic led_on(input int a, input int b);
    for (int i = a; i <= b; i++) x_led[i] = 1'b1;
  endtask
  task automatic busy_on(input int a, input int b);
    for (int i = a; i <= b; i++) x_busy[i] = 1'b1;
  endtask
  task automatic ovf_on(input int a, input int b);
    for (int i = a; i <= b; i++) x_ovf[i] = 1'b1;
  endtask
  task automatic pend_set(input int a, input int b, input logic [PW-1:0] v);
    for (int i = a; i <= b; i++) x_pend[i] = v;
  endtask

  task automatic run(input string nm, input int n);
    @(negedge Fg_CLK);
    RESETn = 1'b0; IntEVT = 1'b0;
    repeat (2) @(negedge Fg_CLK);
    for (int e = 1; e <= n; e++) begin
      exp_t m;
      m.cyc = cyc + e; m.edge_n = e; m.nm = nm;
      m.led = x_led[e]; m.busy = x_busy[e]; m.ovf = x_ovf[e]; m.pend = x_pend[e];
      q.push_back(m);
    end
    for (int e = 1; e <= n; e++) begin
      RESETn = s_rst[e];
      IntEVT = s_evt[e];
      @(negedge Fg_CLK);
    end
    IntEVT = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d expectations outstanding", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held low while events pulse: everything stays at reset values
    clr();
    for (int i = 1; i <= 8; i++) s_rst[i] = 1'b0;
    pulse(2, 3); pulse(5, 5); pulse(7, 7);
    run("reset_hold", 8);

    clr(); pulse(10, 10);
    led_on(10, 12); busy_on(10, 14);
    run("single", 20);

    clr(); pulse(10, 12);
    led_on(10, 12); led_on(15, 17); led_on(20, 22); busy_on(10, 24);
    pend_set(11, 11, 2'd1); pend_set(12, 14, 2'd2); pend_set(15, 19, 2'd1);
    run("queueing", 28);

    clr(); pulse(10, 14);
    led_on(10, 12); led_on(15, 17); led_on(20, 22); led_on(25, 27); busy_on(10, 29);
    pend_set(11, 11, 2'd1); pend_set(12, 12, 2'd2); pend_set(13, 14, 2'd3);
    pend_set(15, 19, 2'd2); pend_set(20, 24, 2'd1);
    ovf_on(14, 32);
    run("saturation", 32);

    clr(); pulse(10, 10); pulse(15, 15);
    led_on(10, 12); led_on(15, 17); busy_on(10, 19);
    run("back_to_back", 25);

    clr(); pulse(10, 12); s_rst[11] = 1'b0;
    led_on(10, 10); led_on(12, 14); busy_on(10, 10); busy_on(12, 16);
    run("reset_mid", 20);

    repeat (2) @(negedge Fg_CLK);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never compared, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
